// File: rtl/hc194_pkg.sv
// Shared op codes, FSM state encodings and HC194 mode constants for the HC194 command sequencer.
package hc194_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  // Op codes are chosen to equal the HC194 mode they drive.
  function automatic logic [1:0] mode_of(input logic [1:0] op);
    return op;
  endfunction

endpackage

// File: rtl/hc194_rep_cnt.sv
// Loadable CNT_W-bit down-counter; o_last flags the final cycle of a run (count == 1).
module hc194_rep_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hc194_seq_ctrl.sv
// Command sequencer driving an HC194 universal shift register cycle by cycle.
// Optional feature macro ROTATE_EN: feeds Q_fb back into DSR/DSL for rotate commands.
module hc194_seq_ctrl
  import hc194_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sin,
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] D,
  output logic             DSR,
  output logic             DSL,
  output logic             busy,
  output logic             done
);

  state_e           r_state, w_next;
  logic [1:0]       r_op, r_s, w_s_nxt;
  logic [WIDTH-1:0] r_d;
  logic             r_sin, r_dsr, r_dsl, r_busy, r_done;
  logic             w_busy_nxt, w_done_nxt, w_accept, w_zero, w_last, w_sin_cur;
  logic [CNT_W-1:0] w_load_val;

  assign cmd_ready  = (r_state == ST_IDLE);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_zero     = (cmd_op != OP_LOAD) && (cmd_cnt == '0);
  assign w_load_val = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_cnt;
  assign w_sin_cur  = w_accept ? cmd_sin : r_sin;

  hc194_rep_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (Clk),
    .i_rst      (MR),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ST_RUN),
    .o_last     (w_last)
  );

  always_comb begin
    w_next     = r_state;
    w_s_nxt    = S_HOLD;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_busy_nxt = 1'b1;
        if (w_zero) begin
          w_next     = ST_DONE;
          w_done_nxt = 1'b1;
        end else begin
          w_next  = ST_RUN;
          w_s_nxt = mode_of(cmd_op);
        end
      end
      ST_RUN: begin
        w_busy_nxt = 1'b1;
        if (w_last) begin
          w_next     = ST_DONE;
          w_done_nxt = 1'b1;
        end else begin
          w_s_nxt = mode_of(r_op);
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_sin   <= 1'b0;
      r_d     <= '0;
      r_s     <= S_HOLD;
      r_dsr   <= 1'b0;
      r_dsl   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= cmd_op;
        r_sin <= cmd_sin;
        r_d   <= cmd_data;
      end
      r_s    <= w_s_nxt;
      r_dsr  <= (w_s_nxt == S_SHR) & w_sin_cur;
      r_dsl  <= (w_s_nxt == S_SHL) & w_sin_cur;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign S    = r_s;
  assign D    = r_d;
  assign busy = r_busy;
  assign done = r_done;

`ifdef ROTATE_EN
  logic r_rot;

  always_ff @(posedge Clk or posedge MR) begin
    if (MR)            r_rot <= 1'b0;
    else if (w_accept) r_rot <= cmd_rot;
  end

  // Rotate path is combinational from Q_fb so the wrapped bit lands on the same edge.
  assign DSR = (r_rot && r_s == S_SHR) ? Q_fb[WIDTH-1] : r_dsr;
  assign DSL = (r_rot && r_s == S_SHL) ? Q_fb[0]       : r_dsl;
`else
  logic w_unused_rot;
  assign w_unused_rot = ^{cmd_rot, Q_fb};
  assign DSR = r_dsr;
  assign DSL = r_dsl;
`endif

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Bench: hc194_seq_ctrl driving a behavioural HC194, Q fed back to Q_fb; table vectors plus corner sequences.
module tb_hc194_seq_ctrl;

`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       MR;
  logic       cmd_valid, cmd_ready, cmd_sin, cmd_rot;
  logic [1:0] cmd_op, S;
  logic [3:0] cmd_cnt, cmd_data, D, Q;
  logic       DSR, DSL, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  hc194_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
    .Clk(Clk), .MR(MR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
    .cmd_rot(cmd_rot), .Q_fb(Q), .S(S), .D(D), .DSR(DSR), .DSL(DSL),
    .busy(busy), .done(done)
  );

  // Behavioural HC194: 01 shifts toward Q3 with DSR into Q0, 10 shifts toward Q0 with DSL into Q3.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) Q <= 4'b0000;
    else case (S)
      2'b01:   Q <= {Q[2:0], DSR};
      2'b10:   Q <= {DSL, Q[3:1]};
      2'b11:   Q <= D;
      default: Q <= Q;
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] cnt;
    logic [3:0] data;
    logic       sin;
    logic       rot;
    logic [3:0] exp_q;
    int         exp_lat;
    int         exp_act;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] data,
                           input logic sin, input logic rot);
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_sin = sin; cmd_rot = rot;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w, lat, act_nz, act_op, dones;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge Clk);
    drive_cmd(v.op, v.cnt, v.data, v.sin, v.rot);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge Clk); w++; end
    if (w >= 50) chk({tag, "_ready_timeout"}, 0, 1);
    @(posedge Clk); #1 cmd_valid = 1'b0;
    lat = -1; act_nz = 0; act_op = 0; dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      if (S != 2'b00) act_nz++;
      if (S != 2'b00 && S == v.op) act_op++;
      if (done) begin
        dones++;
        if (lat < 0) lat = i;
      end
      if (lat >= 0 && !done && cmd_ready) break;
    end
    chk({tag, "_q"},      32'(Q),     32'(v.exp_q));
    chk({tag, "_lat"},    lat,        v.exp_lat);
    chk({tag, "_s_any"},  act_nz,     v.exp_act);
    chk({tag, "_s_op"},   act_op,     v.exp_act);
    chk({tag, "_dones"},  dones,      1);
    chk({tag, "_ready"},  32'(cmd_ready), 1);
  endtask

  initial begin
    int dn, acc_i, w;
    logic [3:0] q_at_done;

    //          op     cnt    data     sin   rot   exp_q                          lat act
    tbl[0]  = '{2'b11, 4'd0,  4'b1010, 1'b0, 1'b0, 4'b1010,                        1,  1};
    tbl[1]  = '{2'b11, 4'd7,  4'b0000, 1'b0, 1'b0, 4'b0000,                        1,  1};
    tbl[2]  = '{2'b01, 4'd3,  4'b1111, 1'b1, 1'b0, 4'b0111,                        3,  3};
    tbl[3]  = '{2'b10, 4'd2,  4'b0000, 1'b0, 1'b0, 4'b0001,                        2,  2};
    tbl[4]  = '{2'b01, 4'd0,  4'b0000, 1'b1, 1'b0, 4'b0001,                        0,  0};
    tbl[5]  = '{2'b00, 4'd5,  4'b1111, 1'b1, 1'b0, 4'b0001,                        5,  0};
    tbl[6]  = '{2'b11, 4'd0,  4'b1000, 1'b0, 1'b0, 4'b1000,                        1,  1};
    tbl[7]  = '{2'b01, 4'd1,  4'b0000, 1'b0, 1'b1, ROT ? 4'b0001 : 4'b0000,        1,  1};
    tbl[8]  = '{2'b11, 4'd0,  4'b1000, 1'b0, 1'b0, 4'b1000,                        1,  1};
    tbl[9]  = '{2'b01, 4'd4,  4'b0000, 1'b0, 1'b1, ROT ? 4'b1000 : 4'b0000,        4,  4};
    tbl[10] = '{2'b10, 4'd15, 4'b0000, 1'b1, 1'b0, 4'b1111,                       15, 15};
    tbl[11] = '{2'b10, 4'd1,  4'b0000, 1'b0, 1'b1, ROT ? 4'b1111 : 4'b0111,        1,  1};

    // Reset, with a command offered during MR that must be ignored.
    MR = 1'b1; cmd_valid = 1'b1;
    drive_cmd(2'b11, 4'd0, 4'b1111, 1'b1, 1'b0);
    repeat (3) @(negedge Clk);
    cmd_valid = 1'b0;
    MR = 1'b0;
    @(negedge Clk);
    chk("rst_s",     32'(S),         0);
    chk("rst_d",     32'(D),         0);
    chk("rst_dsr",   32'(DSR),       0);
    chk("rst_dsl",   32'(DSL),       0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_done",  32'(done),      0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_q",     32'(Q),         0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Reset during the second cycle of an 8-cycle shift.
    @(negedge Clk);
    drive_cmd(2'b01, 4'd8, 4'b0000, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    @(posedge Clk); #1 cmd_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("mr_pre_s",    32'(S),    1);
    chk("mr_pre_busy", 32'(busy), 1);
    MR = 1'b1;
    #1;
    chk("mr_s",    32'(S),    0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_q",    32'(Q),    0);
    @(negedge Clk);
    MR = 1'b0;
    dn = 0;
    w  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (done) dn++;
      if (S != 2'b00 || busy) w++;
    end
    chk("mr_no_done", dn, 0);
    chk("mr_idle",    w,  0);
    chk("mr_q_after", 32'(Q), 0);

    // Second command held valid while busy: stalled until the cycle after DONE.
    @(negedge Clk);
    drive_cmd(2'b01, 4'd2, 4'b0000, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    drive_cmd(2'b11, 4'd0, 4'b0101, 1'b0, 1'b0);
    acc_i = -1; dn = 0; q_at_done = 4'hx;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (done) begin dn++; q_at_done = Q; end
      if (cmd_valid && cmd_ready) begin
        acc_i = i;
        @(posedge Clk); #1 cmd_valid = 1'b0;
        break;
      end
    end
    chk("stall_acc_cycle", acc_i, 3);
    chk("stall_done1",     dn,    1);
    chk("stall_q_done1",   32'(q_at_done), 32'(4'b0011));
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (done) dn++;
    end
    chk("stall_done2", dn, 1);
    chk("stall_q2",    32'(Q), 32'(4'b0101));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
